// File: rtl/servant_uart_pkg.sv
// Shared types and bit positions for the servant Wishbone UART transmitter.
package servant_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Status word bit positions and the write-data command bit.
    localparam int STAT_EMPTY  = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_BUSY   = 2;
    localparam int STAT_OVF    = 3;
    localparam int CMD_CLR_OVF = 8;

endpackage

// File: rtl/servant_uart_fifo.sv
// Byte FIFO as a circular buffer; the caller never pushes when full or pops when empty.
module servant_uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_empty,
    output logic       o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (i_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({i_push, i_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately left out of reset; only the pointers matter.
    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_ptr_q] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/servant_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter: bus writes fill a FIFO drained by a serialiser.
module servant_uart_tx
    import servant_uart_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_rdt,
    output logic        o_tx,
    output logic        o_irq
);

    localparam logic [15:0] BAUD_LOAD = 16'(CLK_DIV - 1);

    // Bus handshake: i_wb_cyc is a one-cycle strobe per access with no ack; a write
    // takes effect at the end of that cycle and read data is valid in the same cycle.
    logic wr, clr_cmd, push, pop, empty, full, busy;
    logic [7:0] fifo_rdata;

    uart_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;

    logic unused_dat;
    assign unused_dat = ^i_wb_dat[31:9];

    assign wr      = i_wb_cyc & i_wb_we;
    assign clr_cmd = i_wb_dat[CMD_CLR_OVF];
    assign push    = wr & ~clr_cmd & ~full;

    servant_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pop   (pop),
        .i_wdata (i_wb_dat[7:0]),
        .o_rdata (fifo_rdata),
        .o_empty (empty),
        .o_full  (full)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (wr) begin
            if (clr_cmd)   ovf_d = 1'b0;
            else if (full) ovf_d = 1'b1;
        end
    end

    // o_tx is registered: each transition sets the line level for the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = BAUD_LOAD;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = BAUD_LOAD;
                    idx_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = BAUD_LOAD;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        cnt_d   = BAUD_LOAD;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign o_tx  = tx_q;
    assign o_irq = empty & ~busy;

    always_comb begin
        o_wb_rdt             = '0;
        o_wb_rdt[STAT_EMPTY] = empty;
        o_wb_rdt[STAT_FULL]  = full;
        o_wb_rdt[STAT_BUSY]  = busy;
        o_wb_rdt[STAT_OVF]   = ovf_q;
    end

endmodule
